// File: rtl/csa_stream_accumulator.sv
// csa_stream_accumulator
// Framed streaming adder. Operands are folded into a carry-save pair (s, c)
// with one 3:2 compression per accepted beat. At the end of a frame the pair
// is resolved by a chunked ripple adder that handles CHUNK bits per cycle.
// The result is then held on a valid/ready output until it is taken.
module csa_stream_accumulator #(
   parameter int N     = 8,
   parameter int ACC_W = 16,
   parameter int CHUNK = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [N-1:0]     in_data,
   input  logic             in_last,
   output logic             in_ready,
   output logic             out_valid,
   output logic [ACC_W-1:0] out_data,
   output logic [CNT_W-1:0] out_count,
   output logic             out_overflow,
   input  logic             out_ready
);

   localparam int NCH = ACC_W / CHUNK;
   localparam int K_W = $clog2(NCH + 1);
   // k_r runs one step past the last chunk. That extra cycle folds the final
   // carry into the overflow flag, so the result appears NCH+1 edges after the
   // last beat.
   localparam logic [K_W-1:0] K_LAST = K_W'(NCH);

   typedef enum logic [1:0] {
      ACCUM   = 2'd0,
      RESOLVE = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t             state_r, state_nxt_s;
   logic [ACC_W-1:0]   s_r, c_r, res_r;
   logic               carry_r;
   logic [CNT_W-1:0]   cnt_r;
   logic               ovf_r;
   logic [K_W-1:0]     k_r;

   logic               accept_s;
   logic [ACC_W-1:0]   x_s;
   logic [ACC_W-1:0]   m_s;
   logic [CHUNK:0]     chunk_s;

   assign in_ready     = (state_r == ACCUM);
   assign out_valid    = (state_r == DONE);
   assign out_data     = res_r;
   assign out_count    = cnt_r;
   assign out_overflow = ovf_r;

   assign accept_s = in_valid && in_ready;
   assign x_s      = {{(ACC_W-N){1'b0}}, in_data};
   assign m_s      = (s_r & c_r) | (s_r & x_s) | (c_r & x_s);
   // During resolve, s_r and c_r shift right each cycle, so the live chunk is always at bit 0.
   assign chunk_s  = {1'b0, s_r[CHUNK-1:0]} + {1'b0, c_r[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_r};

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ACCUM;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic for the frame sequence ACCUM -> RESOLVE -> DONE.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ACCUM: begin
            if (accept_s && in_last) begin
               state_nxt_s = RESOLVE;
            end else begin
               state_nxt_s = ACCUM;
            end
         end
         RESOLVE: begin
            if (k_r == K_LAST) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = RESOLVE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nxt_s = ACCUM;
            end else begin
               state_nxt_s = DONE;
            end
         end
         default: state_nxt_s = ACCUM;
      endcase
   end

   // Datapath: carry-save accumulate, chunked resolve, and clear on result handoff.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_r     <= {ACC_W{1'b0}};
         c_r     <= {ACC_W{1'b0}};
         res_r   <= {ACC_W{1'b0}};
         carry_r <= 1'b0;
         cnt_r   <= {CNT_W{1'b0}};
         ovf_r   <= 1'b0;
         k_r     <= {K_W{1'b0}};
      end else begin
         case (state_r)
            ACCUM: begin
               if (accept_s) begin
                  s_r   <= s_r ^ c_r ^ x_s;
                  c_r   <= {m_s[ACC_W-2:0], 1'b0};
                  ovf_r <= ovf_r | m_s[ACC_W-1];
                  if (cnt_r != {CNT_W{1'b1}}) begin
                     cnt_r <= cnt_r + CNT_W'(1);
                  end
                  if (in_last) begin
                     k_r     <= {K_W{1'b0}};
                     carry_r <= 1'b0;
                  end
               end
            end
            RESOLVE: begin
               if (k_r != K_LAST) begin
                  res_r   <= {chunk_s[CHUNK-1:0], res_r[ACC_W-1:CHUNK]};
                  s_r     <= s_r >> CHUNK;
                  c_r     <= c_r >> CHUNK;
                  carry_r <= chunk_s[CHUNK];
                  k_r     <= k_r + K_W'(1);
               end else begin
                  ovf_r   <= ovf_r | carry_r;
               end
            end
            DONE: begin
               if (out_ready) begin
                  s_r     <= {ACC_W{1'b0}};
                  c_r     <= {ACC_W{1'b0}};
                  res_r   <= {ACC_W{1'b0}};
                  carry_r <= 1'b0;
                  cnt_r   <= {CNT_W{1'b0}};
                  ovf_r   <= 1'b0;
                  k_r     <= {K_W{1'b0}};
               end
            end
            default: begin
               s_r <= {ACC_W{1'b0}};
               c_r <= {ACC_W{1'b0}};
            end
         endcase
      end
   end

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Testbench for csa_stream_accumulator. The driver pushes the expected result
// of each frame into a scoreboard queue. A monitor pops and compares the
// entry whenever a result handshake occurs.
module tb_csa_stream_accumulator;

   localparam int N     = 8;
   localparam int ACC_W = 16;
   localparam int CHUNK = 4;
   localparam int CNT_W = 8;
   localparam int LAT   = ACC_W / CHUNK + 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic [N-1:0]     in_data = '0;
   logic             in_last = 1'b0;
   logic             in_ready;
   logic             out_valid;
   logic [ACC_W-1:0] out_data;
   logic [CNT_W-1:0] out_count;
   logic             out_overflow;
   logic             out_ready = 1'b1;

   typedef struct {
      logic [ACC_W-1:0] data;
      logic [CNT_W-1:0] count;
      logic             ovf;
   } exp_t;

   exp_t         sb_q[$];
   logic [7:0]   beats[$];
   int           n_checks = 0;
   int           n_fail   = 0;

   csa_stream_accumulator #(.N(N), .ACC_W(ACC_W), .CHUNK(CHUNK), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_last      (in_last),
      .in_ready     (in_ready),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_count    (out_count),
      .out_overflow (out_overflow),
      .out_ready    (out_ready)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard monitor: compare each result as it is handed off.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            check_eq("unexpected_result", 32'(out_data), 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check_eq("out_data", 32'(out_data), 32'(e.data));
            check_eq("out_count", 32'(out_count), 32'(e.count));
            check_eq("out_overflow", 32'(out_overflow), 32'(e.ovf));
         end
      end
   end

   // Drive the beats in the queue 'beats'. If push is set, record the expected
   // result. If wait_res is set, measure the latency to out_valid.
   task automatic send_frame(input bit push, input bit wait_res);
      int   total;
      int   n;
      exp_t e;
      total = 0;
      for (int i = 0; i < beats.size(); i++) begin
         total += int'(beats[i]);
         if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_data  = beats[i];
         in_last  = (i == beats.size() - 1);
         n = 0;
         while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
         end
         if (!in_ready) check_eq("in_ready_timeout", 32'd0, 32'd1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = 8'h00;
      e.data  = ACC_W'(total);
      e.count = (beats.size() > 255) ? 8'd255 : CNT_W'(beats.size());
      e.ovf   = (total >= 65536);
      if (push) sb_q.push_back(e);
      if (wait_res) begin
         n = 0;
         while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
         end
         check_eq("latency", 32'(n), 32'(LAT));
      end
   endtask

   task automatic idle(input int cycles);
      repeat (cycles) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      #3;
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_out_data", 32'(out_data), 32'd0);
      check_eq("rst_out_count", 32'(out_count), 32'd0);
      check_eq("rst_out_overflow", 32'(out_overflow), 32'd0);
      check_eq("rst_in_ready", 32'(in_ready), 32'd1);
      #10 rst = 1'b0;
      @(posedge clk); #1;

      beats = '{8'h01, 8'h02, 8'h03};
      send_frame(1'b1, 1'b1);
      idle(2);

      beats = '{8'hFF, 8'h01, 8'h01};
      send_frame(1'b1, 1'b1);
      idle(1);

      beats = '{8'hAA};
      send_frame(1'b1, 1'b1);
      @(posedge clk); #1;
      check_eq("ready_after_single", 32'(in_ready), 32'd1);
      beats = '{8'h55, 8'h33};
      send_frame(1'b1, 1'b1);
      idle(1);

      beats.delete();
      for (int i = 0; i < 258; i++) beats.push_back(8'hFF);
      send_frame(1'b1, 1'b1);
      idle(1);

      // Backpressure: the result is held, and input beats are refused.
      out_ready = 1'b0;
      beats = '{8'h10, 8'h20};
      send_frame(1'b1, 1'b1);
      in_valid = 1'b1;
      in_data  = 8'h77;
      in_last  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check_eq("bp_out_valid", 32'(out_valid), 32'd1);
         check_eq("bp_out_data", 32'(out_data), 32'h30);
         check_eq("bp_out_count", 32'(out_count), 32'd2);
         check_eq("bp_in_ready", 32'(in_ready), 32'd0);
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check_eq("bp_ready_after", 32'(in_ready), 32'd1);
      check_eq("bp_valid_after", 32'(out_valid), 32'd0);
      idle(1);

      // Asynchronous reset in the middle of RESOLVE.
      beats = '{8'h12, 8'h34, 8'h56};
      send_frame(1'b0, 1'b0);
      idle(2);
      #2 rst = 1'b1;
      #1;
      check_eq("arst_out_valid", 32'(out_valid), 32'd0);
      check_eq("arst_out_data", 32'(out_data), 32'd0);
      check_eq("arst_out_count", 32'(out_count), 32'd0);
      check_eq("arst_out_overflow", 32'(out_overflow), 32'd0);
      check_eq("arst_in_ready", 32'(in_ready), 32'd1);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) begin
         check_eq("arst_no_valid", 32'(out_valid), 32'd0);
         @(posedge clk); #1;
      end
      beats = '{8'h12, 8'h34, 8'h56};
      send_frame(1'b1, 1'b1);
      idle(3);

      check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
